// File: rtl/sysmmu_tg_sequencer.sv
// sysmmu_tg_sequencer
// Run sequencer for the segment-MMU traffic generator. Waits for DDR4
// calibration plus a settle delay, holds core_ext_start high while the
// generator runs, then judges the run: PASS on tg_done, FAIL on a protocol
// checker assertion, calibration loss or timeout. The first checker status
// that caused a failure is latched for readout.
//
// Optional feature: define SYSMMU_TG_SEQ_STOP_EN to add the core_ext_stop
// output, a one-cycle pulse whenever the RUN state is left.
module sysmmu_tg_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned RUN_CYCLES    = 1000000,
   parameter int unsigned PC_WIDTH      = 160
) (
   input  logic                ui_clk,
   input  logic                ui_clk_rst_n,
   input  logic                enable,
   input  logic                calib_complete,
   input  logic                tg_done,
   input  logic                pc_asserted_m,
   input  logic [PC_WIDTH-1:0] pc_status_m,
   input  logic                pc_asserted_s,
   input  logic [PC_WIDTH-1:0] pc_status_s,
   output logic                core_ext_start,
   output logic                busy,
   output logic                pass,
   output logic                fail,
   output logic [2:0]          fail_code,
   output logic [PC_WIDTH-1:0] err_status,
`ifdef SYSMMU_TG_SEQ_STOP_EN
   output logic                core_ext_stop,
`endif
   output logic [31:0]         run_cycles
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_CAL = 3'd1,
      SETTLE   = 3'd2,
      RUN      = 3'd3,
      PASS     = 3'd4,
      FAIL     = 3'd5
   } state_t;

   // A zero settle length still spends one cycle in SETTLE.
   localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);
   localparam logic        TIMEOUT_EN  = (RUN_CYCLES != 0);
   localparam logic [31:0] RUN_LAST    = 32'(RUN_CYCLES - 1);

   localparam logic [2:0] CODE_NONE    = 3'd0;
   localparam logic [2:0] CODE_MASTER  = 3'd1;
   localparam logic [2:0] CODE_SLAVE   = 3'd2;
   localparam logic [2:0] CODE_BOTH    = 3'd3;
   localparam logic [2:0] CODE_CALIB   = 3'd4;
   localparam logic [2:0] CODE_TIMEOUT = 3'd5;

   state_t              state_q;
   logic [31:0]         settleCnt_q;
   logic                start_q;
   logic                busy_q;
   logic                pass_q;
   logic                fail_q;
   logic [2:0]          failCode_q;
   logic [PC_WIDTH-1:0] errStatus_q;
   logic [31:0]         runCycles_q;
`ifdef SYSMMU_TG_SEQ_STOP_EN
   logic                stop_q;
`endif

   logic                pcHit_d;
   logic [2:0]          pcCode_d;
   logic [PC_WIDTH-1:0] pcStatus_d;
   logic [31:0]         runCyclesInc_d;

   // Classify a checker hit this cycle; master status wins when both fire.
   always_comb begin
      pcHit_d    = pc_asserted_m | pc_asserted_s;
      pcCode_d   = CODE_NONE;
      pcStatus_d = '0;
      if (pc_asserted_m && pc_asserted_s) begin
         pcCode_d   = CODE_BOTH;
         pcStatus_d = pc_status_m;
      end else if (pc_asserted_m) begin
         pcCode_d   = CODE_MASTER;
         pcStatus_d = pc_status_m;
      end else if (pc_asserted_s) begin
         pcCode_d   = CODE_SLAVE;
         pcStatus_d = pc_status_s;
      end
   end

   // Saturating run-cycle count for the current RUN cycle.
   always_comb begin
      runCyclesInc_d = runCycles_q;
      if (runCycles_q != 32'hFFFF_FFFF) begin
         runCyclesInc_d = runCycles_q + 32'd1;
      end
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge ui_clk or negedge ui_clk_rst_n) begin
      if (!ui_clk_rst_n) begin
         state_q     <= IDLE;
         settleCnt_q <= '0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         failCode_q  <= CODE_NONE;
         errStatus_q <= '0;
         runCycles_q <= '0;
`ifdef SYSMMU_TG_SEQ_STOP_EN
         stop_q      <= 1'b0;
`endif
      end else begin
`ifdef SYSMMU_TG_SEQ_STOP_EN
         stop_q <= 1'b0;
`endif
         if (!enable) begin
`ifdef SYSMMU_TG_SEQ_STOP_EN
            if (state_q == RUN) begin
               stop_q <= 1'b1;
            end
`endif
            state_q     <= IDLE;
            settleCnt_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            failCode_q  <= CODE_NONE;
            errStatus_q <= '0;
            runCycles_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= WAIT_CAL;
                  busy_q  <= 1'b1;
               end
               WAIT_CAL: begin
                  if (calib_complete) begin
                     state_q     <= SETTLE;
                     settleCnt_q <= '0;
                     runCycles_q <= '0;
                  end
               end
               SETTLE: begin
                  if (pcHit_d) begin
                     state_q     <= FAIL;
                     busy_q      <= 1'b0;
                     fail_q      <= 1'b1;
                     failCode_q  <= pcCode_d;
                     errStatus_q <= pcStatus_d;
                  end else if (!calib_complete) begin
                     state_q <= WAIT_CAL;
                  end else if (settleCnt_q == SETTLE_LAST) begin
                     state_q <= RUN;
                     start_q <= 1'b1;
                  end else begin
                     settleCnt_q <= settleCnt_q + 32'd1;
                  end
               end
               RUN: begin
                  runCycles_q <= runCyclesInc_d;
                  if (pcHit_d) begin
                     state_q     <= FAIL;
                     start_q     <= 1'b0;
                     busy_q      <= 1'b0;
                     fail_q      <= 1'b1;
                     failCode_q  <= pcCode_d;
                     errStatus_q <= pcStatus_d;
`ifdef SYSMMU_TG_SEQ_STOP_EN
                     stop_q      <= 1'b1;
`endif
                  end else if (!calib_complete) begin
                     state_q    <= FAIL;
                     start_q    <= 1'b0;
                     busy_q     <= 1'b0;
                     fail_q     <= 1'b1;
                     failCode_q <= CODE_CALIB;
`ifdef SYSMMU_TG_SEQ_STOP_EN
                     stop_q     <= 1'b1;
`endif
                  end else if (TIMEOUT_EN && (runCycles_q == RUN_LAST)) begin
                     state_q    <= FAIL;
                     start_q    <= 1'b0;
                     busy_q     <= 1'b0;
                     fail_q     <= 1'b1;
                     failCode_q <= CODE_TIMEOUT;
`ifdef SYSMMU_TG_SEQ_STOP_EN
                     stop_q     <= 1'b1;
`endif
                  end else if (tg_done) begin
                     state_q <= PASS;
                     start_q <= 1'b0;
                     busy_q  <= 1'b0;
                     pass_q  <= 1'b1;
`ifdef SYSMMU_TG_SEQ_STOP_EN
                     stop_q  <= 1'b1;
`endif
                  end
               end
               PASS, FAIL: begin
                  state_q <= state_q;
               end
               default: begin
                  state_q <= IDLE;
                  start_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign core_ext_start = start_q;
   assign busy           = busy_q;
   assign pass           = pass_q;
   assign fail           = fail_q;
   assign fail_code      = failCode_q;
   assign err_status     = errStatus_q;
   assign run_cycles     = runCycles_q;
`ifdef SYSMMU_TG_SEQ_STOP_EN
   assign core_ext_stop  = stop_q;
`endif

endmodule

// File: doc/sysmmu_tg_sequencer.md
# sysmmu_tg_sequencer

Run sequencer that drives the segment-MMU traffic generator and judges the run. It sits upstream of the sysmmu wrapper's `core_ext_start_0` input and downstream of the DDR4 MC calibration flag and the two AXI protocol checkers (`pc_status_*` / `pc_asserted_*`). It waits for calibration and a settle delay, then starts traffic. It ends the run as PASS on generator done, or as FAIL on a checker assertion, calibration loss or timeout, and latches the first error status for readout.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1024: cycles spent in SETTLE after calibration before start; 0 is treated as 1.
- `RUN_CYCLES`, default 1000000: RUN timeout in cycles; 0 disables the timeout.
- `PC_WIDTH`, default 160: protocol-checker status width.

Ports:
- `ui_clk`, in, 1: the single clock; all ports are synchronous to it.
- `ui_clk_rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level; 1 requests a run, 0 returns the block to IDLE.
- `calib_complete`, in, 1: MC `init_calib_complete`, already in the `ui_clk` domain.
- `tg_done`, in, 1: traffic generator finished (level or pulse).
- `pc_asserted_m`, in, 1 / `pc_status_m`, in, `PC_WIDTH`: master-side checker.
- `pc_asserted_s`, in, 1 / `pc_status_s`, in, `PC_WIDTH`: slave-side checker.
- `core_ext_start`, out, 1: traffic generator start, held high in RUN.
- `busy`, out, 1: high in WAIT_CAL, SETTLE and RUN.
- `pass`, out, 1 / `fail`, out, 1: sticky verdict.
- `fail_code`, out, 3: 0 none, 1 master checker, 2 slave checker, 3 both checkers, 4 calib lost, 5 timeout.
- `err_status`, out, `PC_WIDTH`: latched checker status.
- `run_cycles`, out, 32: number of cycles spent in RUN.

## Operation
States and transitions:
- IDLE → WAIT_CAL when `enable`=1.
- WAIT_CAL → SETTLE when `calib_complete`=1. Entering SETTLE clears the settle counter and `run_cycles`.
- SETTLE → RUN after `SETTLE_CYCLES` cycles in SETTLE.
- SETTLE → WAIT_CAL if `calib_complete` drops.
- SETTLE → FAIL on any `pc_asserted_*`.
- RUN is left on events, evaluated each cycle with this priority: checker assertion > `calib_complete`=0 (code 4) > timeout (code 5) > `tg_done` (→ PASS).
- PASS and FAIL are sticky while `enable`=1. They go to IDLE when `enable`=0.
- `enable`=0 in any state → IDLE next cycle; verdict, code and status are cleared.

Behaviour details:
- Checker codes: master only → code 1; slave only → code 2; both in the same cycle → code 3.
- `err_status` captures `pc_status_m` for codes 1 and 3, and `pc_status_s` for code 2, on the failing cycle. It is zero for codes 4 and 5. Only the first error is captured; nothing updates it afterwards.
- `run_cycles` increments once per RUN cycle and saturates at 0xFFFFFFFF. It freezes in PASS/FAIL.
- Timeout fires when the `RUN_CYCLES`-th RUN cycle completes with no higher-priority event.
- Checker inputs are ignored in IDLE, WAIT_CAL, PASS and FAIL.

## Timing
- All outputs are registered. Reset values: `core_ext_start`=0, `busy`=0, `pass`=0, `fail`=0, `fail_code`=0, `err_status`=0, `run_cycles`=0. State resets to IDLE.
- `core_ext_start` rises on the first RUN cycle, one clock after the last SETTLE cycle. It falls on the cycle the state becomes PASS or FAIL.
- Verdict latency: an event sampled at edge N makes `pass`/`fail`/`fail_code`/`err_status` valid after edge N, all in the same cycle.
- Reset mid-run drops `core_ext_start` immediately (asynchronously).
- `tg_done` and a checker assertion in the same cycle → FAIL.

## Configuration
- `SYSMMU_TG_SEQ_STOP_EN` defined: adds output `core_ext_stop` (1 bit, reset 0). It is a one-cycle pulse on the cycle RUN exits to PASS or FAIL, and also when `enable` drops during RUN.
- `SYSMMU_TG_SEQ_STOP_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Normal run: `enable`=1; `calib_complete` rises at cycle 10; `SETTLE_CYCLES`=4; `tg_done` 100 cycles after start. Required: start high for exactly 100 cycles, then `pass`=1, `fail_code`=0, `run_cycles`=100.
- Checker hit: `pc_asserted_s`=1 with `pc_status_s`=0x…DEAD on RUN cycle 7. Required: `fail`=1, code 2, `err_status`=0x…DEAD. A later `pc_asserted_m` leaves the code and status unchanged.
- Simultaneous events: `pc_asserted_m` and `pc_asserted_s` on the same cycle as `tg_done`. Required: `fail`, code 3, `err_status`=`pc_status_m`.
- Timeout and calib loss:
  - `RUN_CYCLES`=50 with no done → FAIL, code 5, `run_cycles`=50.
  - Separate run: `calib_complete` drops in SETTLE → back to WAIT_CAL with start never asserted.
  - Separate run: `calib_complete` drops in RUN → FAIL, code 4.
- Re-arm and reset: `enable`=0 after PASS → IDLE with all outputs cleared; re-enable repeats the run. `ui_clk_rst_n` asserted mid-RUN → start drops asynchronously, all outputs zero.
- With `SYSMMU_TG_SEQ_STOP_EN`: a single `core_ext_stop` pulse on the RUN exit cycle in each of the above cases.
